lsu_byte_sequencer: RTL and testbench

- Load/store initiator between the core's memory stage and the byte-wide data memory.
- The data memory stores one byte per address, has a single write port and an asynchronous read port.
- This block turns one RV32 load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into 1, 2 or 4 sequential byte beats, little-endian.
- It then returns one response: sign/zero-extended load data, a store acknowledge, or an error.

---
 rtl/lsu_byte_sequencer_pkg.sv | 39 +++
 rtl/lsu_byte_sequencer_load_extend.sv | 23 ++
 rtl/lsu_byte_sequencer.sv | 143 ++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_byte_sequencer_pkg.sv
// Shared encodings for the byte-serial load/store sequencer. The funct3
// constants are also used by the core decode stage.
package lsu_byte_sequencer_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  // Number of byte beats for an access size (funct3[1:0]).
  function automatic logic [2:0] beat_count(logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Illegal funct3, unsigned store, or misaligned halfword/word.
  function automatic logic req_is_err(logic we, logic [2:0] funct3, logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) err = 1'b1;
    if (we && funct3[2]) err = 1'b1;
    if (funct3[1:0] == 2'b01 && addr_lo[0] != 1'b0) err = 1'b1;
    if (funct3[1:0] == 2'b10 && addr_lo != 2'b00) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/lsu_byte_sequencer_load_extend.sv
// Combinational sign/zero extension of the gathered load bytes.
module lsu_byte_sequencer_load_extend
  import lsu_byte_sequencer_pkg::*;
(
  input  logic [31:0] lanes,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  // Select and extend the lanes according to the access type.
  always_comb begin
    rdata = '0;
    case (funct3)
      F3_B:    rdata = {{24{lanes[7]}}, lanes[7:0]};
      F3_BU:   rdata = {24'b0, lanes[7:0]};
      F3_H:    rdata = {{16{lanes[15]}}, lanes[15:0]};
      F3_HU:   rdata = {16'b0, lanes[15:0]};
      F3_W:    rdata = lanes;
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Splits one RV32 load/store into 1, 2 or 4 little-endian byte beats on a
// byte-wide memory and returns a single response.
module lsu_byte_sequencer
  import lsu_byte_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic              mem_sw,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data
);

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [3:0][7:0]   lanes_q, lanes_d;

  logic [31:0]       ext_rdata;
  logic [ADDR_W-1:0] beat_addr;
  logic [2:0]        last_k;
  logic              unused_rd_hi;

  // Only the low byte of the read port carries data.
  assign unused_rd_hi = ^mem_rd_data[31:8];

  assign beat_addr = addr_q + ADDR_W'(k_q);
  assign last_k    = beat_count(f3_q[1:0]) - 3'd1;
  assign req_ready = (state_q == StIdle);

  lsu_byte_sequencer_load_extend u_load_extend (
    .lanes  (lanes_q),
    .funct3 (f3_q),
    .rdata  (ext_rdata)
  );

  // Next-state, beat sequencing and output decode.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    lanes_d     = lanes_q;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    mem_sw      = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    mem_rd_addr = '0;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          k_d     = 2'd0;
          lanes_d = '0;
          err_d   = req_is_err(req_we, req_funct3, req_addr[1:0]);
          state_d = err_d ? StResp : StAccess;
        end
      end
      StAccess: begin
        if (we_q) begin
          mem_sw      = 1'b1;
          mem_wr_addr = beat_addr;
          mem_wr_data = {24'b0, wdata_q[{k_q, 3'b000} +: 8]};
        end else begin
          mem_rd_addr  = beat_addr;
          lanes_d[k_q] = mem_rd_data[7:0];
        end
        if ({1'b0, k_q} == last_k) begin
          state_d = StResp;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'b0 : ext_rdata;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // No memory write or response may escape while reset is held.
    if (rst) begin
      resp_valid  = 1'b0;
      resp_rdata  = '0;
      resp_err    = 1'b0;
      mem_sw      = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      mem_rd_addr = '0;
    end
  end

  // State and request registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= 2'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a byte-wide memory model.
module tb_lsu_byte_sequencer;

  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic          mem_sw;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data;

  logic [7:0] mem [32];

  int checks;
  int errors;

  lsu_byte_sequencer #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_sw      (mem_sw),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: reset loads mem[i] = i, asynchronous read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (mem_sw) begin
      mem[mem_wr_addr] <= mem_wr_data[7:0];
    end
  end
  assign mem_rd_data = {24'b0, mem[mem_rd_addr]};

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_writes;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and follow it to its response.
  task automatic run_req(input vec_t v, input int idx);
    int lat;
    int writes;
    @(negedge clk);
    for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
    check($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat    = 0;
    writes = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_sw) writes++;
      if (resp_valid) begin
        lat = i;
        check($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d err", idx), 32'(resp_err), 32'(v.exp_err));
        break;
      end
    end
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d writes", idx), 32'(writes), 32'(v.exp_writes));
  endtask

  initial begin
    logic [4:0] rdy_seen;
    logic [4:0] rv_seen;
    logic [31:0] rd_seen [5];
    int resp_cnt;

    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = '0;
    req_wdata  = '0;

    //                 we    f3      addr   wdata          exp_rdata     err   lat wr
    vecs[0]  = '{1'b0, 3'b010, 5'd4,  32'h0,        32'h07060504, 1'b0, 5, 0};
    vecs[1]  = '{1'b1, 3'b010, 5'd8,  32'hDEADBEEF, 32'h0,        1'b0, 5, 4};
    vecs[2]  = '{1'b0, 3'b010, 5'd8,  32'h0,        32'hDEADBEEF, 1'b0, 5, 0};
    vecs[3]  = '{1'b1, 3'b000, 5'd3,  32'h00000080, 32'h0,        1'b0, 2, 1};
    vecs[4]  = '{1'b0, 3'b000, 5'd3,  32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 3'b100, 5'd3,  32'h0,        32'h00000080, 1'b0, 2, 0};
    vecs[6]  = '{1'b1, 3'b001, 5'd2,  32'h00008001, 32'h0,        1'b0, 3, 2};
    vecs[7]  = '{1'b0, 3'b001, 5'd2,  32'h0,        32'hFFFF8001, 1'b0, 3, 0};
    vecs[8]  = '{1'b0, 3'b101, 5'd2,  32'h0,        32'h00008001, 1'b0, 3, 0};
    vecs[9]  = '{1'b0, 3'b010, 5'd6,  32'h0,        32'h0,        1'b1, 1, 0};
    vecs[10] = '{1'b1, 3'b001, 5'd1,  32'h0000AAAA, 32'h0,        1'b1, 1, 0};
    vecs[11] = '{1'b0, 3'b011, 5'd0,  32'h0,        32'h0,        1'b1, 1, 0};
    vecs[12] = '{1'b1, 3'b100, 5'd5,  32'h000000FF, 32'h0,        1'b1, 1, 0};
    vecs[13] = '{1'b0, 3'b010, 5'd0,  32'h0,        32'h80010100, 1'b0, 5, 0};
    vecs[14] = '{1'b0, 3'b010, 5'd4,  32'h0,        32'h07060504, 1'b0, 5, 0};

    // Outputs while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in-reset resp_valid", 32'(resp_valid), 32'd0);
    check("in-reset mem_sw", 32'(mem_sw), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    check("reset mem_rd_addr", 32'(mem_rd_addr), 32'd0);
    check("reset mem_wr_data", mem_wr_data, 32'd0);

    for (int i = 0; i < 15; i++) run_req(vecs[i], i);

    // Store interrupted by reset during its third beat.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 5'd12;
    req_wdata  = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst-store beat0 sw", 32'(mem_sw), 32'd1);
    check("rst-store beat0 addr", 32'(mem_wr_addr), 32'd12);
    check("rst-store beat0 data", mem_wr_data, 32'h00000044);
    @(negedge clk);
    check("rst-store beat1 addr", 32'(mem_wr_addr), 32'd13);
    check("rst-store beat1 data", mem_wr_data, 32'h00000033);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst-store beat2 sw gated", 32'(mem_sw), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst req_ready", 32'(req_ready), 32'd1);
    check("post-rst mem_sw", 32'(mem_sw), 32'd0);
    check("post-rst mem12", 32'(mem[12]), 32'd12);
    check("post-rst mem13", 32'(mem[13]), 32'd13);
    resp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) resp_cnt++;
      @(negedge clk);
    end
    check("post-rst no response", 32'(resp_cnt), 32'd0);
    run_req('{1'b0, 3'b010, 5'd12, 32'h0, 32'h0F0E0D0C, 1'b0, 5, 0}, 15);

    // Back-to-back: req_valid held high across two byte loads.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 5'd0;
    check("b2b first ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_addr = 5'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rdy_seen[i] = req_ready;
      rv_seen[i]  = resp_valid;
      rd_seen[i]  = resp_rdata;
      if (i == 3) req_valid = 1'b0;
    end
    check("b2b ready pattern", 32'(rdy_seen), 32'b00100);
    check("b2b resp pattern", 32'(rv_seen), 32'b10010);
    check("b2b rdata first", rd_seen[1], 32'h00000000);
    check("b2b rdata second", rd_seen[4], 32'h00000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
